dcache_refill_ctrl: RTL and testbench

- Miss-handling sequencer for the write-back, direct-mapped data cache in the Memory stage.
- When a load misses, it writes back the dirty victim line to main memory, refills the requested line word by word, then commits tag and valid state.
- It holds Busy high for the whole sequence; the hazard unit ORs Busy into its cache-stall term, so F/D/E/M/W stay frozen until the refilled line produces a hit.

---
 rtl/dcache_refill_ctrl.sv | 142 ++++++++++++++
 tb/tb_dcache_refill_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dcache_refill_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dcache_refill_ctrl: dirty-victim write-back and word-by-word line refill |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dcache_refill_ctrl #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int IDX_WIDTH      = $clog2(WORDS_PER_LINE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     MissM,
  input  logic [ADDRESS_WIDTH-1:0] AddrM,
  input  logic                     VictimDirty,
  input  logic [ADDRESS_WIDTH-1:0] VictimAddr,
  input  logic [DATA_WIDTH-1:0]    VictimData,
  output logic                     MemReq,
  output logic                     MemWE,
  output logic [ADDRESS_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0]    MemWData,
  input  logic                     MemReady,
  input  logic [DATA_WIDTH-1:0]    MemRData,
  output logic                     CacheWE,
  output logic [IDX_WIDTH-1:0]     WordIdx,
  output logic [DATA_WIDTH-1:0]    CacheWData,
  output logic                     SetValid,
  output logic                     Busy
);

  localparam int c_WORD_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int c_OFF_BITS   = $clog2(WORDS_PER_LINE * DATA_WIDTH / 8);
  localparam logic [ADDRESS_WIDTH-1:0] c_LINE_MASK =
    ~ADDRESS_WIDTH'({c_OFF_BITS{1'b1}});
  localparam logic [IDX_WIDTH-1:0] c_LAST_IDX = IDX_WIDTH'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [IDX_WIDTH-1:0]     r_idx;
  logic [ADDRESS_WIDTH-1:0] r_miss_base;
  logic [ADDRESS_WIDTH-1:0] r_victim_base;
  logic [ADDRESS_WIDTH-1:0] w_word_off;
  logic                     w_last;

  // Byte offset of the current beat inside the line; sums wrap modulo 2^ADDRESS_WIDTH.
  assign w_word_off = ADDRESS_WIDTH'(r_idx) << c_WORD_SHIFT;
  assign w_last     = (r_idx == c_LAST_IDX);
  assign Busy       = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    MemReq       = 1'b0;
    MemWE        = 1'b0;
    MemAddr      = '0;
    MemWData     = '0;
    CacheWE      = 1'b0;
    WordIdx      = '0;
    CacheWData   = '0;
    SetValid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MissM) begin
          w_next_state = VictimDirty ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        MemReq   = 1'b1;
        MemWE    = 1'b1;
        MemAddr  = r_victim_base + w_word_off;
        MemWData = VictimData;
        WordIdx  = r_idx;
        if (MemReady && w_last) begin
          w_next_state = S_FILL;
        end
      end
      S_FILL: begin
        MemReq  = 1'b1;
        MemAddr = r_miss_base + w_word_off;
        WordIdx = r_idx;
        if (MemReady) begin
          CacheWE    = 1'b1;
          CacheWData = MemRData;
          if (w_last) begin
            w_next_state = S_DONE;
          end
        end
      end
      S_DONE: begin
        SetValid     = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Victim dirtiness is carried by the WB/FILL choice, so it is not stored separately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx         <= '0;
      r_miss_base   <= '0;
      r_victim_base <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (MissM) begin
            r_miss_base   <= AddrM & c_LINE_MASK;
            r_victim_base <= VictimAddr;
            r_idx         <= '0;
          end
        end
        S_WB, S_FILL: begin
          if (MemReady) begin
            r_idx <= w_last ? '0 : r_idx + 1'b1;
          end
        end
        default: begin
          r_idx <= r_idx;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_refill_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dcache_refill_ctrl: directed and random misses against a beat model   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_dcache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MissM;
  logic [31:0] AddrM;
  logic        VictimDirty;
  logic [31:0] VictimAddr;
  logic [31:0] VictimData;
  logic        MemReq;
  logic        MemWE;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic        MemReady;
  logic [31:0] MemRData;
  logic        CacheWE;
  logic [1:0]  WordIdx;
  logic [31:0] CacheWData;
  logic        SetValid;
  logic        Busy;

  logic [31:0] vline [4];
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    int          idx;
  } beat_t;

  always #5 clk = ~clk;

  // Cache array read port for the victim line
  assign VictimData = vline[WordIdx];

  dcache_refill_ctrl dut (
    .clk(clk), .rst(rst), .MissM(MissM), .AddrM(AddrM),
    .VictimDirty(VictimDirty), .VictimAddr(VictimAddr), .VictimData(VictimData),
    .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemReady(MemReady), .MemRData(MemRData), .CacheWE(CacheWE),
    .WordIdx(WordIdx), .CacheWData(CacheWData), .SetValid(SetValid), .Busy(Busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_req"}, MemReq, 0);
    chk({tag, "_cwe"}, CacheWE, 0);
    chk({tag, "_setv"}, SetValid, 0);
    chk({tag, "_idx"}, WordIdx, 0);
  endtask

  // mode 0: ready every cycle, 1: random, 2: 0,0,1,0,1,...
  // abort: assert reset after two fill beats; drop: release MissM after two fill beats
  task automatic run_miss(input logic [31:0] a, input logic [31:0] va, input bit dirty,
                          input int mode, input bit drop, input bit abort);
    beat_t q[$];
    beat_t b;
    int cycles = 0;
    int fills = 0;
    int p = 0;
    logic [31:0] base;
    base = a - (a % 32'd16);
    for (int i = 0; i < 4; i++) vline[i] = $urandom;
    if (dirty) for (int i = 0; i < 4; i++) begin
      b.we = 1; b.addr = va + 32'(4 * i); b.idx = i; q.push_back(b);
    end
    for (int i = 0; i < 4; i++) begin
      b.we = 0; b.addr = base + 32'(4 * i); b.idx = i; q.push_back(b);
    end

    @(negedge clk);
    MissM = 1; AddrM = a; VictimDirty = dirty; VictimAddr = va; MemReady = 1;
    #1;
    chk_quiet("miss_idle");
    @(posedge clk);

    while (q.size() > 0 && cycles < 200) begin
      @(negedge clk);
      VictimAddr  = $urandom;
      VictimDirty = 1'($urandom);
      if (abort && fills == 2) begin
        #2 rst = 1;
        #1;
        chk("abort_busy", Busy, 0);
        chk("abort_req", MemReq, 0);
        chk("abort_setv", SetValid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("abort_setv2", SetValid, 0);
        MissM = 0;
        rst = 0;
        return;
      end
      if (drop && fills == 2) MissM = 0;
      case (mode)
        0: MemReady = 1;
        1: MemReady = 1'($urandom_range(0, 1));
        default: MemReady = (p >= 2) && (p % 2 == 0);
      endcase
      p++;
      MemRData = $urandom;
      #1;
      chk("busy", Busy, 1);
      chk("req", MemReq, 1);
      chk("setv", SetValid, 0);
      chk("we", MemWE, q[0].we);
      chk("addr", MemAddr, q[0].addr);
      chk("idx", WordIdx, q[0].idx);
      if (q[0].we) chk("wdata", MemWData, vline[q[0].idx]);
      chk("cwe", CacheWE, !q[0].we && MemReady);
      if (!q[0].we && MemReady) chk("cdata", CacheWData, MemRData);
      if (MemReady) begin
        if (!q[0].we) fills++;
        void'(q.pop_front());
      end
      cycles++;
      @(posedge clk);
    end
    chk("beats_done", q.size(), 0);
    if (mode == 0) chk("latency", cycles, dirty ? 8 : 4);

    @(negedge clk);
    MemReady = 1'($urandom);
    #1;
    chk("done_setv", SetValid, 1);
    chk("done_busy", Busy, 1);
    chk("done_req", MemReq, 0);
    chk("done_cwe", CacheWE, 0);
    @(posedge clk);
    @(negedge clk);
    MissM = 0;
    #1;
    chk_quiet("after_done");
    @(posedge clk);
  endtask

  initial begin
    rst = 1; MissM = 1; AddrM = 32'h1234; VictimDirty = 1; VictimAddr = 32'h40;
    MemReady = 1; MemRData = 32'hdead_beef;
    for (int i = 0; i < 4; i++) vline[i] = 32'h0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk_quiet("reset");
      chk("reset_we", MemWE, 0);
      chk("reset_addr", MemAddr, 0);
      chk("reset_wdata", MemWData, 0);
      chk("reset_cdata", CacheWData, 0);
    end
    MissM = 0;
    rst = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk_quiet("idle");
    end

    run_miss(32'h0000_104C, 32'h0000_5000, 0, 0, 0, 0);
    run_miss(32'h0000_1040, 32'h0000_2040, 1, 0, 0, 0);
    run_miss(32'h0000_1040, 32'h0000_2040, 1, 2, 0, 0);
    run_miss(32'h0000_7018, 32'h0000_9000, 0, 0, 0, 1);
    run_miss(32'h0000_3000, 32'h0000_6000, 0, 0, 0, 0);
    run_miss(32'hFFFF_FFF4, 32'hFFFF_FFF0, 0, 0, 1, 0);
    run_miss(32'hFFFF_FFF4, 32'hFFFF_FFF0, 1, 1, 1, 0);
    for (int k = 0; k < 10; k++) begin
      logic [31:0] va;
      va = $urandom & 32'hFFFF_FFF0;
      run_miss($urandom, va, 1'($urandom), 1, 1'($urandom), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
